// File: rtl/asp_dma_wr_fence_gen.sv
// asp_dma_wr_fence_gen: DMA write pass-through that injects a fence-tagged completion write at burst boundaries; ASP_WR_FENCE_TIMEOUT_EN adds a sticky fence timeout
module asp_dma_wr_fence_gen #(
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 512,
  parameter int BURST_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    up_write,
  input  logic [ADDR_WIDTH-1:0]   up_address,
  input  logic [BURST_WIDTH-1:0]  up_burstcount,
  input  logic [DATA_WIDTH-1:0]   up_writedata,
  input  logic [DATA_WIDTH/8-1:0] up_byteenable,
  output logic                    up_waitrequest,
  output logic                    dn_write,
  output logic [ADDR_WIDTH-1:0]   dn_address,
  output logic [BURST_WIDTH-1:0]  dn_burstcount,
  output logic [DATA_WIDTH-1:0]   dn_writedata,
  output logic [DATA_WIDTH/8-1:0] dn_byteenable,
  input  logic                    dn_waitrequest,
  output logic                    wr_fence_flag,
  input  logic                    fence_req,
  input  logic [ADDR_WIDTH-1:0]   fence_addr,
  input  logic [63:0]             fence_data,
  output logic                    fence_busy,
  output logic                    fence_done,
  output logic                    fence_timeout
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  typedef enum logic [1:0] {PASS, BURST, FENCE, DONE} state_t;
  state_t state, state_nx;
  logic pending;
  logic [ADDR_WIDTH-1:0] fence_addr_q;
  logic [63:0] fence_data_q;
  logic [BURST_WIDTH-1:0] beats_left;
  logic up_acc, fence_take, fence_pend, fence_acc, multi;
  assign up_acc = up_write && !dn_waitrequest;
  assign fence_take = fence_req && !pending;
  // a request seen this cycle already counts, so an idle PASS can enter FENCE next cycle
  assign fence_pend = pending || fence_take;
  assign fence_acc = state == FENCE && !dn_waitrequest;
  assign multi = up_burstcount > BURST_WIDTH'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= PASS;
    else state <= state_nx;
  always_comb begin
    state_nx = state == PASS  ? (up_acc && multi ? BURST : fence_pend && !up_acc ? FENCE : PASS)
             : state == BURST ? (up_acc && beats_left == BURST_WIDTH'(1) ? (fence_pend ? FENCE : PASS) : BURST)
             : state == FENCE ? (dn_waitrequest ? FENCE : DONE)
             : PASS;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= 1'b0;
      fence_addr_q <= '0;
      fence_data_q <= '0;
      beats_left <= '0;
    end else begin
      pending <= fence_acc ? 1'b0 : fence_pend;
      if (fence_take) begin
        fence_addr_q <= fence_addr;
        fence_data_q <= fence_data;
      end
      if (state == PASS && up_acc) beats_left <= multi ? up_burstcount - BURST_WIDTH'(1) : '0;
      else if (state == BURST && up_acc) beats_left <= beats_left - BURST_WIDTH'(1);
    end
  always_comb begin
    wr_fence_flag = state == FENCE;
    fence_done = state == DONE;
    fence_busy = pending;
    up_waitrequest = state inside {FENCE, DONE} ? 1'b1 : dn_waitrequest;
    dn_write = wr_fence_flag || (state != DONE && up_write);
    dn_address = wr_fence_flag ? fence_addr_q : up_address;
    dn_burstcount = wr_fence_flag ? BURST_WIDTH'(1) : up_burstcount;
    dn_writedata = wr_fence_flag ? DATA_WIDTH'(fence_data_q) : up_writedata;
    dn_byteenable = wr_fence_flag ? BE_WIDTH'(8'hFF) : up_byteenable;
  end
`ifdef ASP_WR_FENCE_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic to_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      to_cnt <= '0;
      to_q <= 1'b0;
    end else begin
      to_cnt <= state != FENCE ? 16'h0 : (dn_waitrequest && to_cnt != 16'hFFFF) ? to_cnt + 16'h1 : to_cnt;
      to_q <= to_q || to_cnt == 16'hFFFF;
    end
  assign fence_timeout = to_q;
`else
  assign fence_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_asp_dma_wr_fence_gen.sv
// tb_asp_dma_wr_fence_gen: directed fence scenarios plus randomized traffic against a burst/fence protocol model
module tb_asp_dma_wr_fence_gen;
  localparam int AW = 48, DW = 512, BW = 7, BEW = DW / 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic up_write = 1'b0, up_waitrequest, dn_write, dn_waitrequest = 1'b0;
  logic [AW-1:0] up_address = '0, dn_address, fence_addr = '0;
  logic [BW-1:0] up_burstcount = 7'd1, dn_burstcount;
  logic [DW-1:0] up_writedata = '0, dn_writedata;
  logic [BEW-1:0] up_byteenable = '0, dn_byteenable;
  logic wr_fence_flag, fence_req = 1'b0, fence_busy, fence_done, fence_timeout;
  logic [63:0] fence_data = '0;
  always #5 clk = ~clk;
  asp_dma_wr_fence_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .up_write(up_write), .up_address(up_address), .up_burstcount(up_burstcount),
    .up_writedata(up_writedata), .up_byteenable(up_byteenable), .up_waitrequest(up_waitrequest),
    .dn_write(dn_write), .dn_address(dn_address), .dn_burstcount(dn_burstcount),
    .dn_writedata(dn_writedata), .dn_byteenable(dn_byteenable), .dn_waitrequest(dn_waitrequest),
    .wr_fence_flag(wr_fence_flag), .fence_req(fence_req), .fence_addr(fence_addr),
    .fence_data(fence_data), .fence_busy(fence_busy), .fence_done(fence_done),
    .fence_timeout(fence_timeout)
  );
  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit mp = 0, acc_prev = 0;
  logic [AW-1:0] m_addr = '0;
  logic [63:0] m_data = '0;
  int rem = 0, n_cap = 0, n_done = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic rnd_up();
    up_address = AW'({$urandom, $urandom});
    up_writedata = rnd_data();
    up_byteenable = {$urandom, $urandom};
  endtask
  // one clock: protocol checks before the edge, model update from the pre-edge handshake
  task automatic cyc();
    bit acc;
    #1;
    chk("busy", fence_busy, mp);
    chk("done", fence_done, acc_prev);
    if (fence_done) n_done++;
`ifndef ASP_WR_FENCE_TIMEOUT_EN
    chk("timeout_tied", fence_timeout, 0);
`endif
    if (acc_prev) begin
      chk("done_upwait", up_waitrequest, 1);
      chk("done_dnwrite", dn_write, 0);
      chk("done_flag", wr_fence_flag, 0);
    end else if (wr_fence_flag) begin
      chk("f_pending", mp, 1);
      chk("f_boundary", rem, 0);
      chk("f_write", dn_write, 1);
      chk("f_addr", dn_address, m_addr);
      chk("f_bc", dn_burstcount, 1);
      chk("f_data", dn_writedata, DW'(m_data));
      chk("f_be", dn_byteenable, BEW'(8'hFF));
      chk("f_upwait", up_waitrequest, 1);
    end else begin
      chk("p_write", dn_write, up_write);
      chk("p_addr", dn_address, up_address);
      chk("p_bc", dn_burstcount, up_burstcount);
      chk("p_data", dn_writedata, up_writedata);
      chk("p_be", dn_byteenable, up_byteenable);
      chk("p_upwait", up_waitrequest, dn_waitrequest);
    end
    acc = wr_fence_flag && !dn_waitrequest;
    if (up_write && !up_waitrequest) begin
      if (rem == 0) rem = up_burstcount > 1 ? int'(up_burstcount) - 1 : 0;
      else rem--;
    end
    if (acc) mp = 0;
    else if (fence_req && !mp) begin
      mp = 1;
      m_addr = fence_addr;
      m_data = fence_data;
      n_cap++;
    end
    acc_prev = acc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_fence(input logic [AW-1:0] a, input logic [63:0] d);
    up_write = 1'b0;
    fence_req = 1'b1; fence_addr = a; fence_data = d; dn_waitrequest = 1'b1;
    #1 chk("idle_c0_flag", wr_fence_flag, 0);
    cyc();
    fence_req = 1'b0; fence_addr = AW'({$urandom, $urandom}); fence_data = {$urandom, $urandom};
    #1 chk("idle_c1_flag", wr_fence_flag, 1);
    chk("idle_c1_addr", dn_address, a);
    cyc();
    dn_waitrequest = 1'b0;
    #1 chk("idle_c2_flag", wr_fence_flag, 1);
    chk("idle_c2_data", dn_writedata, DW'(d));
    cyc();
    #1 chk("idle_c3_done", fence_done, 1);
    chk("idle_c3_flag", wr_fence_flag, 0);
    cyc();
    #1 chk("idle_c4_done", fence_done, 0);
    chk("idle_c4_busy", fence_busy, 0);
    cyc();
  endtask
  initial begin
    int n_cap0, n_done0;
    logic [AW-1:0] ca;
    logic [63:0] cd;
    repeat (2) @(negedge clk);
    #1 chk("rst_flag", wr_fence_flag, 0);
    chk("rst_busy", fence_busy, 0);
    chk("rst_done", fence_done, 0);
    chk("rst_timeout", fence_timeout, 0);
    reset_n = 1'b1;
    // a zero burstcount beat behaves as a single beat, leaving the block idle
    rnd_up(); up_write = 1'b1; up_burstcount = '0;
    cyc();
    idle_fence(48'h1000, 64'hA5A5_0000_DEAD_BEEF);
    // fence requested mid-burst waits for the eighth beat
    up_write = 1'b1; up_burstcount = 7'd8;
    ca = 48'h0000_2222_0040; cd = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 8; i++) begin
      rnd_up();
      fence_req = i == 2; fence_addr = ca; fence_data = cd;
      #1 chk("mb_beat_flag", wr_fence_flag, 0);
      chk("mb_beat_upwait", up_waitrequest, 0);
      cyc();
    end
    fence_req = 1'b0; up_burstcount = 7'd1; rnd_up();
    #1 chk("mb_fence_flag", wr_fence_flag, 1);
    chk("mb_fence_upwait", up_waitrequest, 1);
    chk("mb_fence_addr", dn_address, ca);
    cyc();
    #1 chk("mb_done", fence_done, 1);
    chk("mb_done_upwait", up_waitrequest, 1);
    cyc();
    up_write = 1'b0;
    cyc();
    // 20 stalled fence cycles, with a second request dropped while busy
    ca = 48'h00AB_CDEF_0100; cd = 64'hFEED_FACE_CAFE_0001;
    fence_req = 1'b1; fence_addr = ca; fence_data = cd; dn_waitrequest = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      fence_req = i == 5; fence_addr = 48'h0BAD_0BAD_0000; fence_data = 64'h0BAD_0BAD_0BAD_0BAD;
      #1 chk("bp_flag", wr_fence_flag, 1);
      chk("bp_addr", dn_address, ca);
      chk("bp_data", dn_writedata, DW'(cd));
      cyc();
    end
    fence_req = 1'b0; dn_waitrequest = 1'b0;
    #1 chk("bp_acc_flag", wr_fence_flag, 1);
    cyc();
    #1 chk("bp_done", fence_done, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_no_second_flag", wr_fence_flag, 0);
      chk("bp_no_second_done", fence_done, 0);
      cyc();
    end
    // reset while the fence write is held
    fence_req = 1'b1; fence_addr = 48'h3000; fence_data = 64'h5555_AAAA_5555_AAAA; dn_waitrequest = 1'b1;
    cyc();
    fence_req = 1'b0;
    #1 chk("rstmid_pre_flag", wr_fence_flag, 1);
    cyc();
    up_write = 1'b1; rnd_up(); reset_n = 1'b0;
    #1 chk("rstmid_flag", wr_fence_flag, 0);
    chk("rstmid_busy", fence_busy, 0);
    chk("rstmid_done", fence_done, 0);
    chk("rstmid_dnwrite", dn_write, 1);
    chk("rstmid_addr", dn_address, up_address);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; up_write = 1'b0; dn_waitrequest = 1'b0;
    mp = 0; rem = 0; acc_prev = 0;
    cyc();
    cyc();
    idle_fence(48'h1000, 64'hA5A5_0000_DEAD_BEEF);
`ifdef ASP_WR_FENCE_TIMEOUT_EN
    fence_req = 1'b1; fence_addr = 48'h4000; fence_data = 64'h7; dn_waitrequest = 1'b1;
    cyc();
    fence_req = 1'b0;
    for (int i = 0; i < 65536; i++) cyc();
    dn_waitrequest = 1'b0;
    cyc();
    cyc();
    #1 chk("timeout_sticky", fence_timeout, 1);
    cyc();
`endif
    n_cap0 = n_cap; n_done0 = n_done;
    for (int i = 0; i < 800; i++) begin
      rnd_up();
      up_write = $urandom_range(0, 3) != 0;
      up_burstcount = $urandom_range(0, 15) == 0 ? '0 : BW'($urandom_range(1, 8));
      fence_req = $urandom_range(0, 9) == 0;
      fence_addr = AW'({$urandom, $urandom});
      fence_data = {$urandom, $urandom};
      dn_waitrequest = $urandom_range(0, 2) == 0;
      cyc();
    end
    fence_req = 1'b0;
    for (int i = 0; i < 200 && (mp || rem > 0 || acc_prev); i++) begin
      rnd_up();
      up_write = rem > 0;
      dn_waitrequest = $urandom_range(0, 3) == 0;
      cyc();
    end
    chk("drain_settled", mp || rem > 0, 0);
    chk("fence_count", n_done - n_done0, n_cap - n_cap0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/asp_dma_wr_fence_gen.md
# asp_dma_wr_fence_gen

Write-stream stage between the DMA write master and the host-memory write mux. It passes DMA write bursts through unchanged. On a fence request it waits for a burst boundary, stalls the DMA, and issues one fence-tagged completion write. That write carries the magic number and asserts `wr_fence_flag`, the fence input of the host-memory mux. After the mux accepts the write, the block pulses completion back to the DMA controller.

## Interface
- `ADDR_WIDTH`, 48, byte-address width of the write channel
- `DATA_WIDTH`, 512, write data width; must be ≥ 64 and a multiple of 8
- `BURST_WIDTH`, 7, burstcount width; legal counts are 1..2^(BURST_WIDTH-1)
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `up_write`, `up_address`, `up_burstcount`, `up_writedata`, `up_byteenable`  in  1/ADDR/BURST/DATA/DATA÷8  Avalon write from DMA
- `up_waitrequest`  out  1  stall to DMA
- `dn_write`, `dn_address`, `dn_burstcount`, `dn_writedata`, `dn_byteenable`  out  as upstream  Avalon write to mux
- `dn_waitrequest`  in  1  stall from mux
- `wr_fence_flag`  out  1  marks the current dn write as the fence write
- `fence_req`  in  1  single-cycle request; sampled only while `fence_busy`=0
- `fence_addr`  in  ADDR_WIDTH  completion address, captured with `fence_req`
- `fence_data`  in  64  magic number, captured with `fence_req`
- `fence_busy`  out  1  fence pending or in flight
- `fence_done`  out  1  one-cycle pulse when the fence write is accepted

## Operation
- FSM states: PASS, BURST, FENCE, DONE.
- **PASS**
  - Dn signals equal up signals; `up_waitrequest` = `dn_waitrequest`.
  - An accepted first beat with burstcount > 1 loads `beats_left` = burstcount−1 and moves to BURST.
  - If a fence is pending and no first beat is accepted this cycle, move to FENCE.
- **BURST**
  - Pass-through continues.
  - Each accepted beat decrements `beats_left`.
  - When the beat taken at `beats_left`=1 is accepted: go to FENCE if a fence is pending, otherwise to PASS.
- **FENCE**
  - `up_waitrequest`=1.
  - `dn_write`=1, `dn_address`=`fence_addr_q`, `dn_burstcount`=1.
  - `dn_writedata`={zeros, `fence_data_q`}, `dn_byteenable`=0xFF in the low 8 bytes and zero elsewhere.
  - `wr_fence_flag`=1.
  - Hold every signal stable until `dn_waitrequest`=0; that cycle is the acceptance. Then go to DONE.
- **DONE**: `fence_done`=1 for one cycle, `fence_busy` clears, go to PASS. Upstream stays stalled this cycle.
- Fence capture:
  - `fence_req` while `fence_busy`=0 registers `fence_addr`/`fence_data` and sets pending; `fence_busy` rises the next cycle.
  - `fence_req` while `fence_busy`=1 is ignored; no queue.
- Simultaneous events:
  - `fence_req` in the same cycle as an accepted first beat: the beat/burst completes first, then FENCE.
  - In PASS with `up_write`=0, the request cycle's state is still PASS; FENCE is entered the next cycle.
- `beats_left` is BURST_WIDTH bits. A burstcount of 0 is illegal input: treat it as 1 and flag nothing.
- `wr_fence_flag` is 0 in every state except FENCE.
- Reset, including assertion mid-operation:
  - State → PASS; `beats_left`, pending, and the fence registers → 0.
  - Outputs: `fence_busy`=0, `fence_done`=0, `wr_fence_flag`=0.
  - Dn signals pass through with `dn_write`=`up_write`.
  - An in-flight fence is dropped and `fence_done` is not pulsed.

## Timing
- Pass-through is combinational: zero latency on the write fields and on `up_waitrequest`.
- Minimum latency from `fence_req` at cycle 0 (idle PASS) to `dn_write` with the flag is cycle 1.
- The mux stalls the first fence cycle, so the earliest acceptance is cycle 2 and the earliest `fence_done` is cycle 3.
- `fence_done` is registered and asserted exactly the cycle after acceptance.
- The fence write is never interleaved inside a burst: the first fence beat is always preceded by the last burst beat being accepted.

## Configuration
- Macro: `ASP_WR_FENCE_TIMEOUT_EN`.
- **Defined**
  - Adds a 16-bit counter that clears on entering FENCE and increments each FENCE cycle with `dn_waitrequest`=1.
  - At 0xFFFF it saturates and sets the sticky output `fence_timeout`=1. Only reset clears it.
  - The fence write keeps being held.
- **Undefined**: counter absent; `fence_timeout` is tied to 0 and the port remains.

## Test plan
- **Idle fence**: `fence_req`, addr=0x1000, data=0xA5A5_0000_DEAD_BEEF, `dn_waitrequest` 1 for one cycle then 0 → one dn write at 0x1000, burstcount 1, flag 1 for 2 cycles, low 64 bits = data, `fence_done` at cycle 3.
- **Mid-burst fence**: 8-beat burst, `fence_req` at beat 3 → all 8 beats pass untouched, the fence write starts the cycle after beat 8 is accepted, `up_waitrequest`=1 during FENCE/DONE.
- **Backpressure**: `dn_waitrequest` high for 20 FENCE cycles → dn fields stable for all 20, exactly one acceptance, one `fence_done`.
- **Busy drop**: second `fence_req` while busy with different data → only the first address/data is written; a single `fence_done`.
- **Reset mid-fence**: deassert `reset_n` during FENCE → all outputs at reset values asynchronously, no `fence_done`; the next `fence_req` behaves as in the idle case.
- **Timeout** (macro defined): hold `dn_waitrequest`=1 for 65535 FENCE cycles → `fence_timeout` rises and stays set after the write is finally accepted.
